// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive controller.
// This package holds the FSM state encoding, the parity polarity and the sample-point helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // The three vote points straddle the middle of the bit.
    function automatic int samp_first(input int prescale);
        return prescale / 2 - 1;
    endfunction

    function automatic int samp_last(input int prescale);
        return prescale / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler around mid-bit.
// samp_bit is updated on the last vote point and then holds until the end of the bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] edge_cnt,
    input  logic       rx_s,
    output logic       samp_bit
);

    localparam int SAMP_FIRST = samp_first(PRESCALE);
    localparam int SAMP_MID   = PRESCALE / 2;
    localparam int SAMP_LAST  = samp_last(PRESCALE);

    logic s0_q, s0_d;
    logic s1_q, s1_d;
    logic samp_q, samp_d;

    always_comb begin
        s0_d   = s0_q;
        s1_d   = s1_q;
        samp_d = samp_q;
        if (edge_cnt == 6'(SAMP_FIRST)) s0_d = rx_s;
        if (edge_cnt == 6'(SAMP_MID))   s1_d = rx_s;
        if (edge_cnt == 6'(SAMP_LAST))
            samp_d = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
            samp_q <= 1'b1;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            samp_q <= samp_d;
        end
    end

    assign samp_bit = samp_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx_in, walks start/data/parity/stop using the
// external edge_bit_cnt, and emits one registered valid/par_err/frm_err pulse per frame.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [3:0]            bit_cnt,
    input  logic [5:0]            edge_cnt,
    output logic                  cnt_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  frm_err,
    output logic                  busy
);

    rx_state_e             state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic                  cnt_en_q, cnt_en_d;
    logic                  busy_q, busy_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;

    logic samp_bit;
    logic end_of_bit;
    logic exp_par;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .edge_cnt (edge_cnt),
        .rx_s     (rx_s_q),
        .samp_bit (samp_bit)
    );

    assign end_of_bit = (edge_cnt == 6'(PRESCALE));
    assign exp_par    = (^shift_q) ^ (par_typ_q == PAR_ODD);

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx_in;
        rx_s_d       = sync1_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        frm_err_d    = 1'b0;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (end_of_bit && bit_cnt == 4'd0)
                    state_d = samp_bit ? IDLE : DATA;
            end
            DATA: begin
                if (end_of_bit) begin
                    shift_d = {samp_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == 4'(DATA_WIDTH))
                        state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (end_of_bit) begin
                    par_bad_d = (samp_bit != exp_par);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (end_of_bit) begin
                    state_d = IDLE;
                    // A bad stop bit hides any parity problem in the same frame.
                    if (!samp_bit) begin
                        frm_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_en_d = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            cnt_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_bad_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            cnt_en_q     <= cnt_en_d;
            busy_q       <= busy_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign frm_err    = frm_err_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART Rx path.
- Sits directly upstream of edge_bit_cnt:
  - drives its cnt_en;
  - consumes its bit_cnt/edge_cnt to time start, data, parity and stop bits.
- Synchronises rx_in, majority-samples each bit, deserialises LSB-first, checks parity and stop.
- Presents a parallel byte with a one-cycle valid pulse, or an error pulse.

Parameters:
- PRESCALE, 8, clocks per bit; even, 4..32; must equal edge_bit_cnt prescale.
- DATA_WIDTH, 8, data bits per frame, 5..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rx_in  in  1  raw serial line, idle high.
- par_en  in  1  1 = frame carries a parity bit.
- par_typ  in  1  0 = even, 1 = odd.
- bit_cnt  in  4  from edge_bit_cnt.
- edge_cnt  in  6  from edge_bit_cnt.
- cnt_en  out  1  enable to edge_bit_cnt.
- p_data  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle pulse; p_data updated.
- par_err  out  1  one-cycle pulse, parity mismatch.
- frm_err  out  1  one-cycle pulse, stop bit sampled 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; sync flops=1; shift reg=0; p_data=0.
  - data_valid, par_err, frm_err, cnt_en, busy = 0.
  - A reset mid-frame aborts the frame with no pulses.
- Synchroniser: rx_in passes through 2 flops; rx_s is the second flop. All decisions use rx_s.
- cnt_en is a Moore output: 1 in every state except IDLE.
- Counter contract:
  - edge_bit_cnt clears while cnt_en=0.
  - First cycle in START sees edge_cnt=0; it then counts 1..PRESCALE.
  - At edge_cnt==PRESCALE it wraps to 1 and bit_cnt increments.
  - "End of bit k" means edge_cnt==PRESCALE with bit_cnt==k.
- Sampler:
  - rx_s captured at edge_cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
  - samp_bit = majority of the 3, registered at edge_cnt==PRESCALE/2+1.
  - samp_bit is stable at end of bit.
- States:
  - IDLE: rx_s==0 -> START. On this transition, latch par_en and par_typ for the whole frame.
  - START (bit 0): at end of bit, samp_bit==0 -> DATA; else -> IDLE (glitch, no pulse).
  - DATA (bits 1..DATA_WIDTH):
    - at each end of bit, shift samp_bit into MSB, shift right (LSB-first).
    - at end of bit DATA_WIDTH: -> PARITY if latched par_en, else -> STOP.
  - PARITY (bit DATA_WIDTH+1):
    - at end of bit, compare samp_bit with expected parity: XOR of data (even) or XNOR (odd).
    - store the mismatch flag; -> STOP.
  - STOP: at end of bit, go -> IDLE, then one of:
    - samp_bit==1 and no mismatch: p_data <= shift reg, data_valid=1.
    - samp_bit==0: frm_err=1; parity mismatch is not reported.
    - samp_bit==1 with mismatch: par_err=1.
- Pulses are registered and high for exactly the first cycle after the end-of-stop edge. At most one pulse per frame.
- p_data changes only with data_valid; failed frames leave it unchanged.
- Back-to-back frames: the FSM spends at least 1 cycle in IDLE (this clears the counters). A start bit arriving then is accepted.
- rx_in changes while not in IDLE affect sampling only; no restart.
- Widths: the max bit index is DATA_WIDTH+2 = 10, which fits bit_cnt. PRESCALE ≤ 32 fits edge_cnt.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN/PAR_ODD constants;
  - localparam helpers SAMP_FIRST = PRESCALE/2-1 and SAMP_LAST = PRESCALE/2+1.
- One sub-module, uart_rx_sampler: 3-point majority vote, inputs edge_cnt and rx_s, output samp_bit.

Test Plan (PRESCALE=8, DATA_WIDTH=8; bit = 8 clocks):
- par_en=0, send 0xA5 (start, 10100101 LSB-first, stop=1) -> data_valid pulse for 1 cycle, p_data=0xA5; err pulses stay 0; cnt_en drops for ≥1 cycle.
- par_en=1, par_typ=0, send 0x3C with parity=0 -> p_data=0x3C, data_valid=1. Repeat with parity=1 -> par_err pulse; p_data stays 0x3C.
- par_en=1, par_typ=1, send 0x01 with parity=0 -> valid, p_data=0x01. Then send 0x55 with stop=0 -> frm_err=1, par_err=0, p_data unchanged.
- rx_in low for 3 clocks then high (glitch) -> FSM back in IDLE after bit 0; no pulse; busy=0. A following real frame 0x7E is received correctly.
- Two frames 0x12, 0x34 back-to-back, one stop bit each -> two data_valid pulses, p_data 0x12 then 0x34.
- Assert rst low mid-DATA -> all outputs 0 immediately, cnt_en=0, state IDLE. Next frame 0xFF -> p_data=0xFF.
